// File: rtl/fios_operand_feeder.sv
// Operand stage for the cascaded FIOS Montgomery multiplier: double-buffers {A, B, P},
// launches the multiplier and serves the A window and B/P limbs on its strobes.
module fios_operand_feeder #(
  parameter int unsigned s      = 8,
  parameter int unsigned PE_NB  = 8,
  parameter int unsigned LIMB_W = 17
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [s*LIMB_W-1:0]       a_load_i,
  input  logic [s*LIMB_W-1:0]       b_load_i,
  input  logic [s*LIMB_W-1:0]       p_load_i,
  output logic                      start_o,
  output logic                      busy_o,
  input  logic                      a_shift_i,
  input  logic                      b_fetch_i,
  input  logic                      p_fetch_i,
  input  logic                      done_i,
  output logic [PE_NB*LIMB_W-1:0]   a_o,
  output logic [LIMB_W-1:0]         b_o,
  output logic [LIMB_W-1:0]         p_o
);

  localparam int unsigned OpW  = s * LIMB_W;
  localparam int unsigned WinW = PE_NB * LIMB_W;
  localparam int unsigned IdxW = (s > 1) ? $clog2(s) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(s - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   start_q, start_d;

  logic [OpW-1:0] a_sh_q, a_sh_d;
  logic [OpW-1:0] b_sh_q, b_sh_d;
  logic [OpW-1:0] p_sh_q, p_sh_d;

  logic [OpW-1:0]              a_act_q, a_act_d;
  logic [s-1:0][LIMB_W-1:0]    b_act_q, b_act_d;
  logic [s-1:0][LIMB_W-1:0]    p_act_q, p_act_d;
  logic [IdxW-1:0]             b_idx_q, b_idx_d;
  logic [IdxW-1:0]             p_idx_q, p_idx_d;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    start_d   = 1'b0;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    p_sh_d    = p_sh_q;
    a_act_d   = a_act_q;
    b_act_d   = b_act_q;
    p_act_d   = p_act_q;
    b_idx_d   = b_idx_q;
    p_idx_d   = p_idx_q;

    // Ready is ~pending, so a load never coincides with the launch that drains the shadow.
    if (load_valid_i && !pending_q) begin
      a_sh_d    = a_load_i;
      b_sh_d    = b_load_i;
      p_sh_d    = p_load_i;
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          a_act_d   = a_sh_q;
          b_act_d   = b_sh_q;
          p_act_d   = p_sh_q;
          pending_d = 1'b0;
          b_idx_d   = '0;
          p_idx_d   = '0;
          start_d   = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (a_shift_i) a_act_d = a_act_q >> WinW;
        // Indices wrap so the multiplier can make several folded passes over B and P.
        if (b_fetch_i) b_idx_d = (b_idx_q == LastIdx) ? '0 : b_idx_q + 1'b1;
        if (p_fetch_i) p_idx_d = (p_idx_q == LastIdx) ? '0 : p_idx_q + 1'b1;
        if (done_i)    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      p_sh_q    <= '0;
      a_act_q   <= '0;
      b_act_q   <= '0;
      p_act_q   <= '0;
      b_idx_q   <= '0;
      p_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      p_sh_q    <= p_sh_d;
      a_act_q   <= a_act_d;
      b_act_q   <= b_act_d;
      p_act_q   <= p_act_d;
      b_idx_q   <= b_idx_d;
      p_idx_q   <= p_idx_d;
    end
  end

  assign load_ready_o = ~pending_q;
  assign start_o      = start_q;
  // Busy is reported from the cycle after the launch pulse.
  assign busy_o       = (state_q == StRun) && !start_q;
  assign a_o          = a_act_q[WinW-1:0];
  assign b_o          = b_act_q[b_idx_q];
  assign p_o          = p_act_q[p_idx_q];

endmodule

// File: tb/tb_fios_operand_feeder.sv
// Self-checking bench for fios_operand_feeder: directed table plus randomized run against
// a limb-index reference model.
module tb_fios_operand_feeder;

  localparam int S  = 8;
  localparam int PE = 3;
  localparam int W  = 17;

  logic              clock;
  logic              reset_n;
  logic              load_valid;
  logic              load_ready;
  logic [S*W-1:0]    a_load, b_load, p_load;
  logic              start, busy;
  logic              a_shift, b_fetch, p_fetch, done;
  logic [PE*W-1:0]   a_win;
  logic [W-1:0]      b_limb, p_limb;

  fios_operand_feeder #(.s(S), .PE_NB(PE), .LIMB_W(W)) dut (
    .clock_i      (clock),
    .reset_i      (reset_n),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .a_load_i     (a_load),
    .b_load_i     (b_load),
    .p_load_i     (p_load),
    .start_o      (start),
    .busy_o       (busy),
    .a_shift_i    (a_shift),
    .b_fetch_i    (b_fetch),
    .p_fetch_i    (p_fetch),
    .done_i       (done),
    .a_o          (a_win),
    .b_o          (b_limb),
    .p_o          (p_limb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic            ash, bf, pf, dn;
    logic [PE*W-1:0] ea;
    logic [W-1:0]    eb, ep;
    logic            ebusy;
  } vec_t;
  vec_t tbl [15];

  // Reference model: operand sets as limb arrays, A window as a limb base offset.
  logic [W-1:0] m_sh_a [S], m_sh_b [S], m_sh_p [S];
  logic [W-1:0] m_ac_a [S], m_ac_b [S], m_ac_p [S];
  bit m_pend, m_run, m_start;
  int m_base, m_bi, m_pi;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_load(input int ab, input int bb, input int pb);
    for (int k = 0; k < S; k++) begin
      a_load[k*W +: W] = W'(ab + k);
      b_load[k*W +: W] = W'(bb + k);
      p_load[k*W +: W] = W'(pb + k);
    end
  endtask

  task automatic strobes(input logic ash, input logic bf, input logic pf, input logic dn);
    a_shift = ash;
    b_fetch = bf;
    p_fetch = pf;
    done    = dn;
  endtask

  function automatic logic [PE*W-1:0] win3(input int a0);
    return {W'(a0 + 2), W'(a0 + 1), W'(a0)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < S; k++) begin
      m_sh_a[k] = '0; m_sh_b[k] = '0; m_sh_p[k] = '0;
      m_ac_a[k] = '0; m_ac_b[k] = '0; m_ac_p[k] = '0;
    end
    m_pend = 0; m_run = 0; m_start = 0;
    m_base = 0; m_bi = 0; m_pi = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit fire;
    bit n_start;
    fire    = load_valid && !m_pend;
    n_start = 0;
    if (!m_run) begin
      if (m_pend) begin
        m_ac_a = m_sh_a; m_ac_b = m_sh_b; m_ac_p = m_sh_p;
        m_pend = 0; m_base = 0; m_bi = 0; m_pi = 0;
        m_run = 1; n_start = 1;
      end
    end else begin
      if (a_shift) m_base = (m_base + PE > S) ? S : m_base + PE;
      if (b_fetch) m_bi = (m_bi + 1) % S;
      if (p_fetch) m_pi = (m_pi + 1) % S;
      if (done)    m_run = 0;
    end
    if (fire) begin
      for (int k = 0; k < S; k++) begin
        m_sh_a[k] = a_load[k*W +: W];
        m_sh_b[k] = b_load[k*W +: W];
        m_sh_p[k] = p_load[k*W +: W];
      end
      m_pend = 1;
    end
    m_start = n_start;
  endtask

  function automatic logic [PE*W-1:0] model_win();
    logic [PE*W-1:0] v;
    v = '0;
    for (int j = 0; j < PE; j++)
      if (m_base + j < S) v[j*W +: W] = m_ac_a[m_base + j];
    return v;
  endfunction

  initial begin
    // Directed table: strobes applied for one cycle, outputs expected after the edge.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, win3('h10003), 17'h100, 17'h200, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, {17'h0, 17'h10007, 17'h10006}, 17'h100, 17'h200, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, '0, 17'h100, 17'h200, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, '0, 17'h100, 17'h200, 1'b1};
    for (int i = 4; i <= 10; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, W'('h101 + i - 4), 17'h200, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, 17'h100, 17'h200, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, '0, 17'h101, 17'h200, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, '0, 17'h101, 17'h201, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, '0, 17'h101, 17'h201, 1'b0};

    reset_n = 1'b0;
    load_valid = 1'b0;
    a_load = '0; b_load = '0; p_load = '0;
    strobes(0, 0, 0, 0);
    #2;
    chk("rst_ready", 64'(load_ready), 64'd1);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_a", 64'(a_win), 64'd0);
    chk("rst_b", 64'(b_limb), 64'd0);
    chk("rst_p", 64'(p_limb), 64'd0);
    #10 reset_n = 1'b1;
    tick();

    // Single load: cycle t handshake, start in t+2, busy from t+3.
    set_load('h10000, 'h100, 'h200);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("t1_ready", 64'(load_ready), 64'd0);
    chk("t1_start", 64'(start), 64'd0);
    tick();
    chk("t2_start", 64'(start), 64'd1);
    chk("t2_busy", 64'(busy), 64'd0);
    chk("t2_a", 64'(a_win), 64'(win3('h10000)));
    chk("t2_b", 64'(b_limb), 64'h100);
    chk("t2_p", 64'(p_limb), 64'h200);
    chk("t2_ready", 64'(load_ready), 64'd1);
    tick();
    chk("t3_start", 64'(start), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);

    for (int i = 0; i < 15; i++) begin
      strobes(tbl[i].ash, tbl[i].bf, tbl[i].pf, tbl[i].dn);
      tick();
      strobes(0, 0, 0, 0);
      chk($sformatf("tbl%0d_a", i), 64'(a_win), 64'(tbl[i].ea));
      chk($sformatf("tbl%0d_b", i), 64'(b_limb), 64'(tbl[i].eb));
      chk($sformatf("tbl%0d_p", i), 64'(p_limb), 64'(tbl[i].ep));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].ebusy));
      chk($sformatf("tbl%0d_start", i), 64'(start), 64'd0);
    end

    // Double buffering: set 2 loads during RUN, set 3 held off, relaunch after one IDLE cycle.
    set_load('h3000, 'h3100, 'h3200);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    chk("db1_start", 64'(start), 64'd1);
    chk("db1_a", 64'(a_win), 64'(win3('h3000)));
    tick();
    set_load('h5000, 'h5100, 'h5200);
    load_valid = 1'b1;
    tick();
    chk("db_ready_drop", 64'(load_ready), 64'd0);
    set_load('h7000, 'h7100, 'h7200);
    tick();
    chk("db_held_ready", 64'(load_ready), 64'd0);
    chk("db_held_busy", 64'(busy), 64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("db_idle_start", 64'(start), 64'd0);
    chk("db_idle_busy", 64'(busy), 64'd0);
    chk("db_idle_ready", 64'(load_ready), 64'd0);
    tick();
    load_valid = 1'b0;
    chk("db2_start", 64'(start), 64'd1);
    chk("db2_a", 64'(a_win), 64'(win3('h5000)));
    chk("db2_b", 64'(b_limb), 64'h5100);
    chk("db2_p", 64'(p_limb), 64'h5200);
    chk("db2_ready", 64'(load_ready), 64'd1);
    tick();
    chk("db2_busy", 64'(busy), 64'd1);
    done = 1'b1;
    tick();
    done = 1'b0;

    // Stray strobes in IDLE with nothing pending.
    strobes(1, 1, 1, 1);
    tick();
    strobes(0, 0, 0, 0);
    chk("stray_a", 64'(a_win), 64'(win3('h5000)));
    chk("stray_b", 64'(b_limb), 64'h5100);
    chk("stray_p", 64'(p_limb), 64'h5200);
    chk("stray_start", 64'(start), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    tick();
    chk("stray_start2", 64'(start), 64'd0);

    // Async reset between edges in RUN, then a fresh load.
    set_load('h9000, 'h9100, 'h9200);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    tick();
    #3 reset_n = 1'b0;
    #1;
    chk("arst_a", 64'(a_win), 64'd0);
    chk("arst_b", 64'(b_limb), 64'd0);
    chk("arst_p", 64'(p_limb), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_start", 64'(start), 64'd0);
    chk("arst_ready", 64'(load_ready), 64'd1);
    #2 reset_n = 1'b1;
    tick();
    set_load('hA000, 'hA100, 'hA200);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    chk("post_rst_ready", 64'(load_ready), 64'd0);
    tick();
    chk("post_rst_start", 64'(start), 64'd1);
    chk("post_rst_a", 64'(a_win), 64'(win3('hA000)));

    // Randomized run against the reference model, starting from a fresh reset.
    #3 reset_n = 1'b0;
    model_reset();
    #3 reset_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      load_valid = ($urandom_range(0, 99) < 30);
      for (int k = 0; k < S; k++) begin
        a_load[k*W +: W] = W'($urandom);
        b_load[k*W +: W] = W'($urandom);
        p_load[k*W +: W] = W'($urandom);
      end
      a_shift = ($urandom_range(0, 99) < 20);
      b_fetch = ($urandom_range(0, 99) < 30);
      p_fetch = ($urandom_range(0, 99) < 30);
      done    = ($urandom_range(0, 99) < 6);
      model_step();
      tick();
      chk("rnd_ready", 64'(load_ready), 64'(!m_pend));
      chk("rnd_start", 64'(start), 64'(m_start));
      chk("rnd_busy", 64'(busy), 64'(m_run && !m_start));
      chk("rnd_a", 64'(a_win), 64'(model_win()));
      chk("rnd_b", 64'(b_limb), 64'(m_ac_b[m_bi]));
      chk("rnd_p", 64'(p_limb), 64'(m_ac_p[m_pi]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fios_operand_feeder.md
Name: fios_operand_feeder

Overview:
- Upstream operand stage for the cascaded FIOS Montgomery multiplier.
- Accepts a full operand set {A, B, P} of s 17-bit limbs each through a valid/ready handshake, double-buffered so the next set can load during a multiplication.
- Launches the multiplier with a start pulse, presents the PE_NB-limb A window, and serves B and P limbs one at a time on the multiplier's fetch strobes.

Parameters:
- s, 8: number of 17-bit limbs per operand (s >= 2).
- PE_NB, 8: number of PEs, i.e. the A-window width in limbs (1 <= PE_NB <= s).
- LIMB_W, 17: limb width in bits (fixed by DSP slice; not to be overridden).

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- load_valid_i  in  1  operand set present on a/b/p_load_i.
- load_ready_o  out  1  shadow buffer free.
- a_load_i  in  s*17  operand A, limb 0 in bits [16:0].
- b_load_i  in  s*17  operand B, same packing.
- p_load_i  in  s*17  modulus P, same packing.
- start_o  out  1  one-cycle launch pulse to the multiplier.
- busy_o  out  1  multiplication in flight.
- a_shift_i  in  1  multiplier request to advance the A window.
- b_fetch_i  in  1  multiplier consumed current B limb.
- p_fetch_i  in  1  multiplier consumed current P limb.
- done_i  in  1  multiplier completion pulse.
- a_o  out  PE_NB*17  current A window; PE j sees bits [17j+16:17j].
- b_o  out  17  current B limb.
- p_o  out  17  current P limb.

Behaviour:
- Reset (reset_i=0, async) clears:
  - all buffers and outputs to 0;
  - state IDLE, pending=0;
  - load_ready_o=1, start_o=0, busy_o=0.
- Registers:
  - shadow {A,B,P} plus pending flag;
  - active A shift register (s*17), active B and P (s*17);
  - b_idx and p_idx, each $clog2(s) bits.
- Load:
  - load_ready_o = ~pending, registered-equivalent with no combinational path from load_valid_i.
  - Transfer when load_valid_i && load_ready_o: shadow <= inputs, pending <= 1.
- FSM: IDLE, RUN.
  - IDLE && pending:
    - active <= shadow; pending <= 0;
    - b_idx, p_idx <= 0; state <= RUN; start_o <= 1 for exactly one cycle.
  - RUN: busy_o=1.
  - RUN && done_i: state <= IDLE. If pending is already set, relaunch on the following cycle (one IDLE cycle minimum between start pulses).
- Latency:
  - handshake accepted in cycle t with buffer empty and IDLE: start_o=1 in cycle t+2;
  - a_o, b_o, p_o hold limbs 0 in that same cycle.
- A window:
  - a_o = low PE_NB*17 bits of the active A shift register.
  - a_shift_i in RUN: shift right by PE_NB*17 with zero fill.
  - After ceil(s/PE_NB) shifts the window reads 0; further shifts keep 0.
- B/P:
  - b_o = active B limb[b_idx].
  - b_fetch_i in RUN: b_idx <= (b_idx==s-1) ? 0 : b_idx+1, wrapping for folded multi-pass operation.
  - p_fetch_i and p_idx behave identically and independently.
- Strobes outside RUN:
  - a_shift_i, b_fetch_i and p_fetch_i are ignored outside RUN;
  - done_i is ignored outside RUN.
- Simultaneous events:
  - Handshake in the same cycle as a launch: allowed only if pending was 0. Since ready = ~pending, a launch consumes pending and a new load cannot coincide; by construction shadow is never overwritten while pending=1.
  - done_i together with a_shift_i, b_fetch_i or p_fetch_i: the fetches and shift are applied, and the state still goes to IDLE.
  - done_i and load handshake in the same cycle: both take effect; launch follows next cycle.
- Reset mid-operation: async clear of everything above; any in-flight multiplication result is discarded by the downstream stage.
- No arithmetic is performed on the data; limbs pass through unmodified.

Test Plan:
- Reset then single load, s=8, PE_NB=3, A limbs 0x1_0000+k, B=0x100+k, P=0x200+k:
  - start_o high exactly in cycle t+2, busy_o=1 from t+3;
  - a_o = {0x10002,0x10001,0x10000}, b_o=0x100, p_o=0x200.
- A shifting with the same setup and a_shift_i pulsed four times:
  - a_o steps to {0x10005,0x10004,0x10003}, then {0,0x10007,0x10006}, then 0 twice.
- Fetch wrap:
  - 9 b_fetch_i pulses: b_o returns to 0x100 after the 8th and shows 0x101 after the 9th;
  - p_o stays 0x200 throughout.
- Double buffering:
  - load set 2 during RUN: load_ready_o drops next cycle;
  - a third load_valid_i is held off;
  - done_i: one IDLE cycle, then start_o with set-2 limbs; load_ready_o re-rises.
- Stray strobes:
  - a_shift_i, b_fetch_i, p_fetch_i and done_i pulsed in IDLE with no pending set: outputs and state unchanged, no start_o.
- Async reset asserted mid-RUN, between clock edges:
  - all outputs 0 immediately, load_ready_o=1;
  - after release, a fresh load launches normally.
